// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller for the five-stage MIPS core. Produces
//            the stall/flush controls for the PC and the IF/ID, ID/EX, EX/MM
//            and MM/WB registers for hazards that EX-stage forwarding cannot
//            resolve:
//              - load-use hazards (one bubble),
//              - multiply/divide occupancy (internal countdown),
//              - data-memory wait states (with a timeout watchdog),
//              - taken-branch squashing.
// Macro    : HAZ_PERF_CNT_EN - when defined, builds a 32-bit counter of
//            cycles with PC_Stall=1 on StallCnt; otherwise StallCnt is 0.
// Ports    : clk, rst_n                    clock / async active-low reset
//            ID_Rs, ID_Rt, ID_UseRs/Rt     ID source registers and use flags
//            ID_MdUse                      ID instruction touches HI/LO unit
//            EX_Rd, EX_RegWr, EX_MemRd     EX destination / write / load
//            EX_BrTaken                    branch resolved taken in EX
//            EX_MdStart, EX_MdDiv          multiply/divide issue and select
//            MM_MemReq, MM_MemAck          data-memory handshake in MM
//            *_Stall, *_Flush              pipeline register controls
//            MD_Busy, MD_Done              multiply/divide status
//            MemTimeout                    sticky memory-timeout flag
//            StallCnt                      stall-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_MdUse,
  input  logic [4:0]  EX_Rd,
  input  logic        EX_RegWr,
  input  logic        EX_MemRd,
  input  logic        EX_BrTaken,
  input  logic        EX_MdStart,
  input  logic        EX_MdDiv,
  input  logic        MM_MemReq,
  input  logic        MM_MemAck,
  output logic        PC_Stall,
  output logic        IF_ID_Stall,
  output logic        ID_EX_Stall,
  output logic        EX_MM_Stall,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MM_WB_Flush,
  output logic        MD_Busy,
  output logic        MD_Done,
  output logic        MemTimeout,
  output logic [31:0] StallCnt
);

  // Counter load values exclude the issue cycle, which is the EX cycle itself.
  localparam logic [5:0] MULT_LOAD   = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD    = 6'(DIV_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_VAL = (MEM_TIMEOUT > 255) ? 8'hFF : 8'(MEM_TIMEOUT);

  logic       mem_wait;
  logic       rs_hit;
  logic       rt_hit;
  logic       load_use;
  logic       md_haz;
  logic       md_busy_int;
  logic       md_done_int;
  logic [5:0] md_cnt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       timeout_flag;

  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mm_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic mm_wb_flush;

  // --------------------------------------------------------------------------
  // Hazard conditions
  // --------------------------------------------------------------------------
  assign mem_wait = MM_MemReq & ~MM_MemAck;

  assign rs_hit   = ID_UseRs & (ID_Rs == EX_Rd);
  assign rt_hit   = ID_UseRt & (ID_Rt == EX_Rd);
  // r0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = EX_MemRd & EX_RegWr & (EX_Rd != 5'd0) & (rs_hit | rt_hit);

  assign md_busy_int = (md_cnt != 6'd0);
  assign md_done_int = (md_cnt == 6'd1);
  // In the done cycle the result is ready, so the dependent instruction may go.
  assign md_haz      = ID_MdUse & md_busy_int & ~md_done_int;

  // --------------------------------------------------------------------------
  // Control priority: memory wait, taken branch, load-use / md hazard.
  // Outputs are forced low while reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    id_ex_stall = 1'b0;
    ex_mm_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mm_wb_flush = 1'b0;
    if (rst_n) begin
      if (mem_wait) begin
        // Freeze everything up to MM; WB receives a bubble. A taken branch
        // in EX stays there and is acted on once the pipeline advances.
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_stall = 1'b1;
        ex_mm_stall = 1'b1;
        mm_wb_flush = 1'b1;
      end else if (EX_BrTaken) begin
        // Squash IF and ID; the hazards of the squashed ID instruction are moot.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use | md_haz) begin
        // Hold IF/ID and send a bubble into EX.
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign PC_Stall    = pc_stall;
  assign IF_ID_Stall = if_id_stall;
  assign ID_EX_Stall = id_ex_stall;
  assign EX_MM_Stall = ex_mm_stall;
  assign IF_ID_Flush = if_id_flush;
  assign ID_EX_Flush = id_ex_flush;
  assign MM_WB_Flush = mm_wb_flush;

  assign MD_Busy = rst_n & md_busy_int;
  assign MD_Done = rst_n & md_done_int;

  // --------------------------------------------------------------------------
  // Multiply/divide occupancy countdown. Runs free once loaded, including
  // through memory waits. A start during a wait is not an issue: the EX
  // instruction is held and will present the start again.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= 6'd0;
    end else if (md_busy_int) begin
      md_cnt <= md_cnt - 6'd1;
    end else if (EX_MdStart & ~mem_wait) begin
      md_cnt <= EX_MdDiv ? DIV_LOAD : MULT_LOAD;
    end
  end

  // --------------------------------------------------------------------------
  // Memory watchdog: saturating count of consecutive wait cycles and a sticky
  // flag that sets on the edge where the count reaches the timeout value.
  // --------------------------------------------------------------------------
  assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : (wait_cnt + 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= 8'd0;
      timeout_flag <= 1'b0;
    end else begin
      wait_cnt <= mem_wait ? wait_inc : 8'd0;
      if (mem_wait && (wait_inc >= TIMEOUT_VAL)) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign MemTimeout = timeout_flag;

  // --------------------------------------------------------------------------
  // Optional stall-cycle performance counter
  // --------------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (pc_stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign StallCnt = stall_cnt;
`else
  assign StallCnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. A table of single-cycle
//            vectors covers the combinational priority logic; hand-written
//            sequences cover multiply/divide occupancy, memory waits with a
//            pending branch, the timeout watchdog and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  // Control bundle order: {PC, IF_ID, ID_EX, EX_MM stall, IF_ID, ID_EX, MM_WB flush}
  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_MEM  = 7'b1111_001;
  localparam logic [6:0] C_BR   = 7'b0000_110;
  localparam logic [6:0] C_LU   = 7'b1100_010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rd;
  logic        ID_UseRs, ID_UseRt, ID_MdUse;
  logic        EX_RegWr, EX_MemRd, EX_BrTaken, EX_MdStart, EX_MdDiv;
  logic        MM_MemReq, MM_MemAck;
  logic        PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MM_Stall;
  logic        IF_ID_Flush, ID_EX_Flush, MM_WB_Flush;
  logic        MD_Busy, MD_Done, MemTimeout;
  logic [31:0] StallCnt;
  logic [6:0]  ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (32),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .ID_UseRs   (ID_UseRs),
    .ID_UseRt   (ID_UseRt),
    .ID_MdUse   (ID_MdUse),
    .EX_Rd      (EX_Rd),
    .EX_RegWr   (EX_RegWr),
    .EX_MemRd   (EX_MemRd),
    .EX_BrTaken (EX_BrTaken),
    .EX_MdStart (EX_MdStart),
    .EX_MdDiv   (EX_MdDiv),
    .MM_MemReq  (MM_MemReq),
    .MM_MemAck  (MM_MemAck),
    .PC_Stall   (PC_Stall),
    .IF_ID_Stall(IF_ID_Stall),
    .ID_EX_Stall(ID_EX_Stall),
    .EX_MM_Stall(EX_MM_Stall),
    .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush),
    .MM_WB_Flush(MM_WB_Flush),
    .MD_Busy    (MD_Busy),
    .MD_Done    (MD_Done),
    .MemTimeout (MemTimeout),
    .StallCnt   (StallCnt)
  );

  assign ctrl = {PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MM_Stall,
                 IF_ID_Flush, ID_EX_Flush, MM_WB_Flush};

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mdu;
    logic [4:0] exrd;
    logic       rw;
    logic       mr;
    logic       br;
    logic       req;
    logic       ack;
    logic [6:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic mdu,
                              input logic [4:0] exrd, input logic rw, input logic mr,
                              input logic br, input logic req, input logic ack,
                              input logic [6:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mdu = mdu;
    v.exrd = exrd; v.rw = rw; v.mr = mr; v.br = br; v.req = req; v.ack = ack;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_MdUse = 1'b0;
    EX_Rd = 5'd0; EX_RegWr = 1'b0; EX_MemRd = 1'b0; EX_BrTaken = 1'b0;
    EX_MdStart = 1'b0; EX_MdDiv = 1'b0; MM_MemReq = 1'b0; MM_MemAck = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ID_Rs = v.rs; ID_Rt = v.rt; ID_UseRs = v.urs; ID_UseRt = v.urt; ID_MdUse = v.mdu;
    EX_Rd = v.exrd; EX_RegWr = v.rw; EX_MemRd = v.mr; EX_BrTaken = v.br;
    MM_MemReq = v.req; MM_MemAck = v.ack;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // A start presented while the unit is busy is unreachable in a correct pipeline.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && EX_MdStart === 1'b1 && MD_Busy === 1'b1) begin
      errors++;
      $display("FAIL md_start_while_busy: got start=1 busy=1, expected no start while busy");
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  vec_t vecs[16];

  initial begin
    //          rs  rt urs urt mdu exrd rw mr br req ack  expected
    vecs[0]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, C_NONE);
    vecs[1]  = mk(5,  3, 1, 1, 0,  5, 1, 1, 0, 0, 0, C_LU);   // LW r5, ID reads Rs=5
    vecs[2]  = mk(0,  3, 1, 0, 0,  0, 1, 1, 0, 0, 0, C_NONE); // load to r0
    vecs[3]  = mk(5,  3, 0, 1, 0,  5, 1, 1, 0, 0, 0, C_NONE); // Rs not used
    vecs[4]  = mk(1,  7, 1, 1, 0,  7, 1, 1, 0, 0, 0, C_LU);   // Rt match
    vecs[5]  = mk(1,  7, 1, 0, 0,  7, 1, 1, 0, 0, 0, C_NONE); // Rt not used
    vecs[6]  = mk(5,  5, 1, 1, 0,  5, 0, 1, 0, 0, 0, C_NONE); // no reg write
    vecs[7]  = mk(5,  5, 1, 1, 0,  5, 1, 0, 0, 0, 0, C_NONE); // ALU op, forwarded
    vecs[8]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 1, 0, 0, C_BR);
    vecs[9]  = mk(5,  0, 1, 0, 0,  5, 1, 1, 1, 0, 0, C_BR);   // branch beats load-use
    vecs[10] = mk(5,  0, 1, 0, 0,  5, 1, 1, 0, 1, 0, C_MEM);  // wait beats load-use
    vecs[11] = mk(5,  0, 1, 0, 0,  5, 1, 1, 0, 1, 1, C_LU);   // released: bubble still due
    vecs[12] = mk(0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 0, C_MEM);  // wait beats branch
    vecs[13] = mk(0,  0, 0, 0, 1,  0, 0, 0, 0, 0, 0, C_NONE); // md use, unit idle
    vecs[14] = mk(0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 1, C_BR);   // acked access, branch
    vecs[15] = mk(31, 31, 1, 1, 0, 31, 1, 1, 0, 0, 0, C_LU);  // highest register

    clear_inputs();
    rst_n = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("reset_busy", 32'(MD_Busy), 32'd0);
    chk("reset_done", 32'(MD_Done), 32'd0);
    chk("reset_timeout", 32'(MemTimeout), 32'd0);
    chk("reset_stallcnt", StallCnt, 32'd0);
    apply(vecs[1]);
    #1;
    chk("reset_forces_ctrl", 32'(ctrl), 32'(C_NONE));
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp));
      next_cycle();
    end
    clear_inputs();

    // ---------------- multiply with dependent MFLO in ID ----------------
    EX_MdStart = 1'b1; EX_MdDiv = 1'b0; ID_MdUse = 1'b1;
    @(negedge clk);
    chk("mul_issue_busy", 32'(MD_Busy), 32'd0);
    chk("mul_issue_ctrl", 32'(ctrl), 32'(C_NONE));
    next_cycle();
    EX_MdStart = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_c%0d", k), 32'(MD_Busy), (k <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("mul_done_c%0d", k), 32'(MD_Done), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("mul_ctrl_c%0d", k), 32'(ctrl), (k <= 2) ? 32'(C_LU) : 32'(C_NONE));
      next_cycle();
    end
    clear_inputs();

    // ---------------- start blocked while memory waits ----------------
    EX_MdStart = 1'b1; MM_MemReq = 1'b1;
    @(negedge clk);
    chk("mdstart_wait_ctrl", 32'(ctrl), 32'(C_MEM));
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("mdstart_wait_busy", 32'(MD_Busy), 32'd0);
    next_cycle();

    // ---------------- memory wait with pending branch ----------------
    MM_MemReq = 1'b1; EX_BrTaken = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("wait_br_c%0d", k), 32'(ctrl), 32'(C_MEM));
      next_cycle();
    end
    MM_MemAck = 1'b1;
    @(negedge clk);
    chk("wait_br_ack", 32'(ctrl), 32'(C_BR));
    chk("wait_br_no_timeout", 32'(MemTimeout), 32'd0);
    next_cycle();
    clear_inputs();

    // ---------------- timeout watchdog (MEM_TIMEOUT=4) ----------------
    // Cycle k is observed after k-1 wait edges; the flag sets on the 4th edge.
    MM_MemReq = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("timeout_c%0d", k), 32'(MemTimeout), (k >= 5) ? 32'd1 : 32'd0);
      next_cycle();
    end
    MM_MemAck = 1'b1;
    @(negedge clk);
    chk("timeout_ack_ctrl", 32'(ctrl), 32'(C_NONE));
    next_cycle();
    clear_inputs();
    repeat (2) next_cycle();
    @(negedge clk);
    chk("timeout_sticky", 32'(MemTimeout), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("timeout_cleared_by_reset", 32'(MemTimeout), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // ---------------- divide with dependent MFLO in ID ----------------
    EX_MdStart = 1'b1; EX_MdDiv = 1'b1; ID_MdUse = 1'b1;
    @(negedge clk);
    chk("div_issue_ctrl", 32'(ctrl), 32'(C_NONE));
    next_cycle();
    EX_MdStart = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("div_busy_c%0d", k), 32'(MD_Busy), (k <= 31) ? 32'd1 : 32'd0);
      chk($sformatf("div_done_c%0d", k), 32'(MD_Done), (k == 31) ? 32'd1 : 32'd0);
      chk($sformatf("div_stall_c%0d", k), 32'(PC_Stall), (k <= 30) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // ---------------- reset mid-divide (count 17) ----------------
    EX_MdStart = 1'b1;
    next_cycle();
    EX_MdStart = 1'b0;
    // Cycle k after issue holds count 32-k; count 17 is reached at k=15.
    repeat (14) next_cycle();
    @(negedge clk);
    chk("div17_busy", 32'(MD_Busy), 32'd1);
    chk("div17_ctrl", 32'(ctrl), 32'(C_LU));
    rst_n = 1'b0;
    #1;
    chk("div17_rst_busy", 32'(MD_Busy), 32'd0);
    chk("div17_rst_ctrl", 32'(ctrl), 32'(C_NONE));
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_mflo_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("post_rst_busy", 32'(MD_Busy), 32'd0);
    chk("post_rst_stallcnt", StallCnt, 32'd0);
    next_cycle();
    clear_inputs();

    // ---------------- stall counter ----------------
    apply(vecs[1]);
    @(negedge clk);
    chk("perf_lu_ctrl", 32'(ctrl), 32'(C_LU));
    next_cycle();
    clear_inputs();
    @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stallcnt", StallCnt, 32'd1);
`else
    chk("perf_stallcnt_tied", StallCnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It drives the stall and flush controls of the PC and the IF/ID, ID/EX, EX/MM and MM/WB registers, which the EX-stage forwarding network cannot cover on its own. It handles:
- load-use hazards;
- multi-cycle multiply/divide occupancy, tracked by an internal countdown;
- data-memory wait states, with a timeout watchdog;
- taken-branch squashing.

## Interface
- `MULT_CYCLES`, 4: multiply latency in cycles, including the issue cycle (≥2).
- `DIV_CYCLES`, 32: divide latency in cycles, including the issue cycle (≥2).
- `MEM_TIMEOUT`, 255: consecutive memory-wait cycles tolerated before the timeout flag sets.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ID_Rs`, `ID_Rt`  in  5  source registers of the instruction in ID.
- `ID_UseRs`, `ID_UseRt`  in  1  ID instruction actually reads Rs / Rt.
- `ID_MdUse`  in  1  ID instruction is MULT/DIV/MFHI/MFLO/MTHI/MTLO.
- `EX_Rd`  in  5  destination register of the instruction in EX.
- `EX_RegWr`  in  1  EX instruction writes the register file.
- `EX_MemRd`  in  1  EX instruction is a load.
- `EX_BrTaken`  in  1  branch/jump resolved taken in EX.
- `EX_MdStart`  in  1  EX issues a multiply (`EX_MdDiv`=0) or a divide (`EX_MdDiv`=1).
- `EX_MdDiv`  in  1  operation select for `EX_MdStart`.
- `MM_MemReq`  in  1  MM stage has an outstanding data-memory access.
- `MM_MemAck`  in  1  data memory completes the access this cycle.
- `PC_Stall`, `IF_ID_Stall`, `ID_EX_Stall`, `EX_MM_Stall`  out  1  hold the register.
- `IF_ID_Flush`, `ID_EX_Flush`, `MM_WB_Flush`  out  1  load a bubble.
- `MD_Busy`  out  1  multiply/divide unit occupied.
- `MD_Done`  out  1  one-cycle pulse in the last busy cycle.
- `MemTimeout`  out  1  sticky error flag.
- `StallCnt`  out  32  stall-cycle counter (see Configuration).

## Operation
Conditions evaluated every cycle:
- **MemWait** = `MM_MemReq` & !`MM_MemAck`.
- **LoadUse** = `EX_MemRd` & `EX_RegWr` & (`EX_Rd`≠0) & ((`ID_UseRs` & `ID_Rs`==`EX_Rd`) | (`ID_UseRt` & `ID_Rt`==`EX_Rd`)).
- **MdHaz** = `ID_MdUse` & `MD_Busy` & !`MD_Done`.

Control priority, highest first; exactly one row applies:
1. **MemWait**: assert all four `*_Stall` and `MM_WB_Flush`. Assert no other flush; a pending branch resolves once EX advances.
2. **`EX_BrTaken`**: assert `IF_ID_Flush` and `ID_EX_Flush`. Assert no stall, so the PC takes the redirect. Any LoadUse or MdHaz on the squashed ID instruction is ignored.
3. **LoadUse | MdHaz**: assert `PC_Stall`, `IF_ID_Stall` and `ID_EX_Flush`, which inserts one bubble per cycle.
4. Otherwise all controls are 0.

Multiply/divide counter, `MdCnt` (6 bits, registered):
- IDLE (`MdCnt`=0): `EX_MdStart` & !MemWait loads `MULT_CYCLES`-1 or `DIV_CYCLES`-1 according to `EX_MdDiv`.
- Busy (`MdCnt`≠0):
  - decrements every cycle, including during MemWait; the unit runs free;
  - `MD_Busy` = (`MdCnt`≠0); `MD_Done` = (`MdCnt`==1);
  - `EX_MdStart` is ignored, because the MdHaz stall makes it unreachable. A bench assertion flags it.

Memory watchdog, `WaitCnt` (8 bits, saturating):
- increments on each MemWait cycle and clears on any non-MemWait cycle;
- `MemTimeout` sets when `WaitCnt` reaches `MEM_TIMEOUT` and clears only on reset.

## Timing
- All stall/flush outputs are combinational from the current inputs and registered state. They are valid in the same cycle and are sampled by the pipeline registers at the next rising edge.
- LoadUse costs exactly 1 bubble. Cycle N+1 has no hazard, because the load has moved to MM and is forwarded from there.
- Multiply issued in cycle N: `MD_Busy` is high in N+1..N+`MULT_CYCLES`-1 and `MD_Done` pulses in N+`MULT_CYCLES`-1. A dependent MFLO in ID therefore issues in N+`MULT_CYCLES`-1.
- Coincident LoadUse and MemWait: only MemWait controls apply. LoadUse is re-evaluated after release and still costs its single bubble.
- Reset (asynchronous, any cycle, including mid-divide or mid-wait):
  - `MdCnt`, `WaitCnt`, `MemTimeout` and `StallCnt` are cleared;
  - while `rst_n`=0, every stall/flush output, `MD_Busy` and `MD_Done` are forced to 0.

## Configuration
- `HAZ_PERF_CNT_EN` defined: `StallCnt` increments by 1 in every cycle with `PC_Stall`=1 and wraps at 2^32.
- Undefined: no counter register is built and `StallCnt` is tied to 0.

## Test plan
- LW r5 in EX (`EX_Rd`=5, `EX_MemRd`=1); ID reads Rs=5 -> one cycle of `PC_Stall`=`IF_ID_Stall`=`ID_EX_Flush`=1, then 0.
- Same as above but `EX_Rd`=0, or `ID_UseRs`=0 -> no stall.
- `EX_MdStart`=1, `EX_MdDiv`=1 at cycle 10 with an MFLO held in ID -> `MD_Busy` high for cycles 11–41, `MD_Done` pulses at 41, stall deasserts at 41.
- `MM_MemReq`=1, `MM_MemAck` held low for 3 cycles with `EX_BrTaken`=1 -> all four stalls plus `MM_WB_Flush` for 3 cycles with no IF/ID flush, then the branch flush in the ack cycle.
- `MEM_TIMEOUT`=4, MemWait for 6 cycles -> `MemTimeout` rises at the 4th cycle and stays 1 after the ack, until `rst_n` pulses low.
- `rst_n` driven low mid-divide (`MdCnt`=17) -> `MD_Busy`=0 immediately; after release, an MFLO proceeds without stall. With `HAZ_PERF_CNT_EN`, `StallCnt` reads 0.
